// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Boot-time loader for the single-cycle core's instruction memory.
// - Accepts a byte stream on a valid/ready handshake.
// - Packs the bytes little-endian into 32-bit words.
// - Writes each word through a one-word write port.
// - Holds the core in reset until the image is complete, then records the
//   core's done as a halt.
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, a trailing
// XOR checksum byte is verified before the core is released.
module imem_boot_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    input  logic              core_done,
    output logic [ADDR_W:0]   word_count,
    output logic              halted,
    output logic              error
);

    // Memory capacity in words: 2**ADDR_W.
    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    // S_FLUSH covers the cycle in which the final word is being written.
    // Release (or the checksum phase) starts in the cycle after that.
    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_FLUSH  = 3'd1,
        S_CHK    = 3'd2,
        S_RUN    = 3'd3,
        S_HALTED = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t      r_state;
    logic [1:0]  r_bc;
    logic [23:0] r_pack;
    logic        w_accept;
    logic [31:0] w_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_xsum;
`endif

    // Ready is decoded straight from the state so a byte can be taken every cycle.
    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            S_LOAD:  in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:   in_ready = 1'b1;
`endif
            default: in_ready = 1'b0;
        endcase
    end

    assign w_accept = in_valid & in_ready;

    // Merge the incoming byte into its lane.
    // Lanes above the current one stay zero, which zero-pads a short final word.
    always_comb begin
        w_word = 32'd0;
        case (r_bc)
            2'd0:    w_word = {24'd0, in_data};
            2'd1:    w_word = {16'd0, in_data, r_pack[7:0]};
            2'd2:    w_word = {8'd0, in_data, r_pack[15:0]};
            2'd3:    w_word = {in_data, r_pack[23:0]};
            default: w_word = 32'd0;
        endcase
    end

    // Loader state machine with registered write port, core reset and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_LOAD;
            r_bc       <= 2'd0;
            r_pack     <= 24'd0;
            imem_we    <= 1'b0;
            imem_addr  <= {ADDR_W{1'b0}};
            imem_wdata <= 32'd0;
            core_rst   <= 1'b1;
            word_count <= {(ADDR_W+1){1'b0}};
            halted     <= 1'b0;
            error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_xsum     <= 8'd0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (word_count == MAX_WORDS) begin
                            // No room left: the byte is dropped and the load fails.
                            r_state <= S_ERR;
                            error   <= 1'b1;
                        end else begin
`ifdef LOADER_CHECKSUM_EN
                            r_xsum <= r_xsum ^ in_data;
`endif
                            if ((r_bc == 2'd3) || in_last) begin
                                imem_we    <= 1'b1;
                                imem_addr  <= word_count[ADDR_W-1:0];
                                imem_wdata <= w_word;
                                word_count <= word_count + {{ADDR_W{1'b0}}, 1'b1};
                                r_bc       <= 2'd0;
                                r_pack     <= 24'd0;
                                if (in_last) begin
                                    r_state <= S_FLUSH;
                                end
                            end else begin
                                r_pack <= w_word[23:0];
                                r_bc   <= r_bc + 2'd1;
                            end
                        end
                    end
                end
                S_FLUSH: begin
`ifdef LOADER_CHECKSUM_EN
                    r_state  <= S_CHK;
`else
                    r_state  <= S_RUN;
                    core_rst <= 1'b0;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_accept) begin
                        // The in_last flag on the checksum byte has no meaning here.
                        if (in_data == r_xsum) begin
                            r_state  <= S_RUN;
                            core_rst <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            error   <= 1'b1;
                        end
                    end
                end
`endif
                S_RUN: begin
                    if (core_done) begin
                        r_state <= S_HALTED;
                        halted  <= 1'b1;
                    end
                end
                S_HALTED: begin
                    r_state <= S_HALTED;
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    // An unreachable encoding means corruption: keep the core held in reset.
                    r_state  <= S_ERR;
                    error    <= 1'b1;
                    core_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader.
// It runs directed and random images against a byte-level reference model.
module tb_imem_boot_loader;

    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          core_done;
    logic [AW:0]   word_count;
    logic          halted;
    logic          error;

    imem_boot_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .core_done  (core_done),
        .word_count (word_count),
        .halted     (halted),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]    img[$];
    logic [AW-1:0] cap_addr[$];
    logic [31:0]   cap_data[$];

    // Capture every write strobe away from the active edge.
    always @(negedge clk) begin
        if (imem_we) begin
            cap_addr.push_back(imem_addr);
            cap_data.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        core_done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        cap_addr.delete();
        cap_data.delete();
    endtask

    // Offer one byte after 'gap' idle cycles and wait (bounded) until it is taken.
    task automatic send_byte(input logic [7:0] d, input logic l, input int gap, output int waits);
        logic acc;
        logic ok;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        ok    = 1'b0;
        waits = 0;
        for (int t = 0; t < 32; t++) begin
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) chk("accept_timeout", {31'd0, ok}, 32'd1);
    endtask

    // Stream img (in_last on its final byte) and check the writes against the model.
    // mode 0: back-to-back; 1: alternate idle cycles; 2: random gaps.
    task automatic run_image(input int mode, input bit bad_cs);
        logic [31:0] exp_w[16];
        logic [7:0]  xs;
        int          n;
        int          nw;
        int          w;
        int          tot;
        int          gap;
        n   = img.size();
        nw  = (n + 3) / 4;
        xs  = 8'd0;
        tot = 0;
        for (int i = 0; i < 16; i++) exp_w[i] = 32'd0;
        for (int i = 0; i < n; i++) begin
            exp_w[i / 4] = exp_w[i / 4] | (32'(img[i]) << (8 * (i % 4)));
            xs = xs ^ img[i];
        end
        cap_addr.delete();
        cap_data.delete();
        for (int i = 0; i < n; i++) begin
            gap = (mode == 0) ? 0 : (mode == 1) ? ((i == 0) ? 0 : 1) : int'($urandom_range(0, 2));
            send_byte(img[i], (i == n - 1), gap, w);
            tot += w;
        end
        if (mode == 0) chk("no_stall", tot, 32'd0);
        // The last byte was accepted at the previous edge, so its write is visible now.
        chk("we_lat", {31'd0, imem_we}, 32'd1);
        chk("last_addr", {{(32-AW){1'b0}}, imem_addr}, 32'(nw - 1));
        chk("hold_in_load", {31'd0, core_rst}, 32'd1);
        @(posedge clk); #1;
        chk("we_pulse", {31'd0, imem_we}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
        chk("chk_hold", {31'd0, core_rst}, 32'd1);
        chk("chk_ready", {31'd0, in_ready}, 32'd1);
        send_byte(xs ^ (bad_cs ? 8'h01 : 8'h00), 1'($urandom_range(0, 1)), 0, w);
        chk("cs_error", {31'd0, error}, bad_cs ? 32'd1 : 32'd0);
        chk("cs_core_rst", {31'd0, core_rst}, bad_cs ? 32'd1 : 32'd0);
`else
        chk("release", {31'd0, core_rst}, 32'd0);
`endif
        chk("n_writes", cap_data.size(), 32'(nw));
        for (int i = 0; i < nw && i < cap_data.size(); i++) begin
            chk("wr_addr", {{(32-AW){1'b0}}, cap_addr[i]}, 32'(i));
            chk("wr_data", cap_data[i], exp_w[i]);
        end
        chk("word_count", {{(31-AW){1'b0}}, word_count}, 32'(nw));
    endtask

    initial begin
        int w;
        int n;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0; core_done = 1'b0;
        do_reset();

        // Reset state.
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", {{(32-AW){1'b0}}, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("rst_wc", {{(31-AW){1'b0}}, word_count}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);

        // Basic load.
        img = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_image(0, 1'b0);
        if (cap_data.size() == 2) begin
            chk("basic_w0", cap_data[0], 32'h00A00513);
            chk("basic_w1", cap_data[1], 32'h00100093);
        end

        // Halt, then reset out of HALTED.
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        chk("halt_rise", {31'd0, halted}, 32'd1);
        @(posedge clk); #1;
        chk("halt_hold", {31'd0, halted}, 32'd1);
        chk("halt_core_rst", {31'd0, core_rst}, 32'd0);
        chk("halt_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("hrst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("hrst_wc", {{(31-AW){1'b0}}, word_count}, 32'd0);
        chk("hrst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0;

        // Reset mid-word: the partial word must be discarded.
        send_byte(8'hEE, 1'b0, 0, w);
        send_byte(8'hEF, 1'b0, 0, w);
        do_reset();
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
        run_image(0, 1'b0);
        if (cap_data.size() == 2) begin
            chk("part_w0", cap_data[0], 32'h04030201);
            chk("part_w1", cap_data[1], 32'h000000AA);
        end

        // Throttled handshake.
        do_reset();
        img = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_image(1, 1'b0);

        // Bytes offered while not ready are ignored.
        in_valid = 1'b1; in_data = 8'h55;
        repeat (3) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("ign_ready", {31'd0, in_ready}, 32'd0);
        chk("ign_wc", {{(31-AW){1'b0}}, word_count}, 32'd2);
        chk("ign_writes", cap_data.size(), 32'd2);

        // Random images.
        repeat (6) begin
            do_reset();
            n = int'($urandom_range(1, CAP * 4));
            img.delete();
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            run_image(2, 1'b0);
        end

        // Overflow: one byte more than capacity, no in_last.
        do_reset();
        for (int i = 0; i < CAP * 4 + 1; i++) send_byte(8'(i + 1), 1'b0, 0, w);
        chk("ovf_error", {31'd0, error}, 32'd1);
        chk("ovf_core_rst", {31'd0, core_rst}, 32'd1);
        chk("ovf_ready", {31'd0, in_ready}, 32'd0);
        chk("ovf_writes", cap_data.size(), 32'(CAP));
        chk("ovf_wc", {{(31-AW){1'b0}}, word_count}, 32'(CAP));
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        @(posedge clk); #1;
        chk("err_no_halt", {31'd0, halted}, 32'd0);
        chk("err_sticky", {31'd0, error}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match, then mismatch.
        do_reset();
        img = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_image(0, 1'b0);
        do_reset();
        img = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_image(0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
